// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared definitions for the execute stage.
//   ALU_OP_W      width of the one-hot ALU op vector
//   OP_*          bit index of each operation inside that vector
//   es_state_e    execute-stage state encoding
//   op_is_long    true for ops that run the multi-cycle mul/div path
package exe_stage_pkg;

  localparam int ALU_OP_W = 19;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_MOD   = 16;
  localparam int OP_DIVU  = 17;
  localparam int OP_MODU  = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } es_state_e;

  function automatic logic op_is_long(input logic [ALU_OP_W-1:0] op);
    return |op[OP_MODU:OP_MUL];
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: bundle of every execute-stage signal except clk/rstn.
//   decode side : ds_to_es_valid, ds_alu_op, ds_src1/2, ds_pc, ds_dest, ds_gr_we, es_allowin
//   alu side    : alu_op, alu_src1/2 (to alu), alu_result, alu_stall (from alu)
//   memory side : ms_allowin, es_to_ms_valid/pc/result/dest/gr_we
//   forwarding  : es_fwd_we/dest/ready/data
//   control     : flush, es_stall_cnt
// Modports: slave = the execute stage itself, master = its surroundings.
interface exe_stage_if
  import exe_stage_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic                ds_to_es_valid;
  logic [ALU_OP_W-1:0] ds_alu_op;
  logic [31:0]         ds_src1;
  logic [31:0]         ds_src2;
  logic [31:0]         ds_pc;
  logic [4:0]          ds_dest;
  logic                ds_gr_we;
  logic                es_allowin;

  logic [ALU_OP_W-1:0] alu_op;
  logic [31:0]         alu_src1;
  logic [31:0]         alu_src2;
  logic [31:0]         alu_result;
  logic                alu_stall;

  logic                ms_allowin;
  logic                es_to_ms_valid;
  logic [31:0]         es_to_ms_pc;
  logic [31:0]         es_to_ms_result;
  logic [4:0]          es_to_ms_dest;
  logic                es_to_ms_gr_we;

  logic                es_fwd_we;
  logic [4:0]          es_fwd_dest;
  logic                es_fwd_ready;
  logic [31:0]         es_fwd_data;

  logic                flush;
  logic [CNT_W-1:0]    es_stall_cnt;

  modport slave (
    input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_pc, ds_dest, ds_gr_we,
    input  alu_result, alu_stall, ms_allowin, flush,
    output es_allowin, alu_op, alu_src1, alu_src2,
    output es_to_ms_valid, es_to_ms_pc, es_to_ms_result, es_to_ms_dest, es_to_ms_gr_we,
    output es_fwd_we, es_fwd_dest, es_fwd_ready, es_fwd_data, es_stall_cnt
  );

  modport master (
    output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_pc, ds_dest, ds_gr_we,
    output alu_result, alu_stall, ms_allowin, flush,
    input  es_allowin, alu_op, alu_src1, alu_src2,
    input  es_to_ms_valid, es_to_ms_pc, es_to_ms_result, es_to_ms_dest, es_to_ms_gr_we,
    input  es_fwd_we, es_fwd_dest, es_fwd_ready, es_fwd_data, es_stall_cnt
  );

endinterface

// File: rtl/exe_stage.sv
// exe_stage: execute-stage pipeline register between decode and memory.
// Holds one decoded instruction, feeds the external alu and keeps its operands
// stable across multi-cycle mul/div, hands the result to the memory stage with
// a valid/allowin handshake, publishes forwarding info and drains a divide that
// was in flight when the instruction got flushed.
// Ports:
//   clk    clock
//   rstn   synchronous, active-low reset
//   es_if  exe_stage_if.slave bundle (decode, alu, memory, forwarding, flush, counter)
//
// state | meaning
// IDLE  | no instruction held, ready to accept
// BUSY  | instruction held, alu working or result waiting for the memory stage
// DRAIN | held instruction flushed while alu still stalls; wait for alu to go idle
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  exe_stage_if.slave   es_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  es_state_e           r_state;
  logic [ALU_OP_W-1:0] r_op;
  logic [31:0]         r_src1;
  logic [31:0]         r_src2;
  logic [31:0]         r_pc;
  logic [4:0]          r_dest;
  logic                r_gr_we;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_ready_go;
  logic w_idle;
  logic w_busy;
  logic w_handshake;
  logic w_allowin;
  logic w_accept;

  assign w_ready_go  = ~es_if.alu_stall;
  assign w_idle      = (r_state == IDLE);
  assign w_busy      = (r_state == BUSY);
  assign w_handshake = w_busy & w_ready_go & es_if.ms_allowin;
  assign w_allowin   = ~es_if.flush & (w_idle | w_handshake);
  assign w_accept    = es_if.ds_to_es_valid & w_allowin;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_pc        <= '0;
      r_dest      <= '0;
      r_gr_we     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_busy && es_if.alu_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end

      if (w_accept) begin
        r_op    <= es_if.ds_alu_op;
        r_src1  <= es_if.ds_src1;
        r_src2  <= es_if.ds_src2;
        r_pc    <= es_if.ds_pc;
        r_dest  <= es_if.ds_dest;
        r_gr_we <= es_if.ds_gr_we;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= BUSY;
        end
        BUSY: begin
          // a flush while the alu is mid mul/div must let the alu finish first
          if (es_if.flush) r_state <= es_if.alu_stall ? DRAIN : IDLE;
          else if (w_handshake) r_state <= w_accept ? BUSY : IDLE;
        end
        DRAIN: begin
          if (!es_if.alu_stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign es_if.es_allowin      = w_allowin;
  // only BUSY drives an op so DRAIN/IDLE never start a spurious mul or div
  assign es_if.alu_op          = w_busy ? r_op : '0;
  assign es_if.alu_src1        = r_src1;
  assign es_if.alu_src2        = r_src2;

  assign es_if.es_to_ms_valid  = w_busy & w_ready_go & ~es_if.flush;
  assign es_if.es_to_ms_pc     = r_pc;
  assign es_if.es_to_ms_result = es_if.alu_result;
  assign es_if.es_to_ms_dest   = r_dest;
  assign es_if.es_to_ms_gr_we  = r_gr_we;

  assign es_if.es_fwd_we       = w_busy & r_gr_we & (r_dest != 5'd0);
  assign es_if.es_fwd_dest     = r_dest;
  assign es_if.es_fwd_ready    = w_ready_go;
  assign es_if.es_fwd_data     = es_if.alu_result;

  assign es_if.es_stall_cnt    = r_stall_cnt;

endmodule
